// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bus for decode_stage.
interface decode_if #(
    parameter int unsigned NUM_REGS    = 12,
    parameter int unsigned INSTR_WIDTH = 9,
    parameter int unsigned REG_WIDTH   = 8,
    parameter int unsigned OP_WIDTH    = 4,
    parameter int unsigned CNT_WIDTH   = 16
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [INSTR_WIDTH-1:0] instruction;
    logic                   in_valid;
    logic                   in_ready;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [OP_WIDTH-1:0]    alu_op;
    logic [AW-1:0]          rs_addr;
    logic [AW-1:0]          rt_addr;
    logic [AW-1:0]          rd_addr;
    logic [REG_WIDTH-1:0]   imm;
    logic                   reg_read;
    logic                   reg_write;
    logic                   car_write;
    logic                   sel_imm;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem2reg;
    logic                   illegal;
    logic                   halt;
    logic                   halted;
    logic [CNT_WIDTH-1:0]   decode_count;

    // Upstream/downstream environment side
    modport master (
        output instruction, in_valid, flush, out_ready,
        input  in_ready, out_valid, alu_op, rs_addr, rt_addr, rd_addr, imm,
               reg_read, reg_write, car_write, sel_imm, mem_read, mem_write,
               mem2reg, illegal, halt, halted, decode_count
    );

    // Decode stage side
    modport slave (
        input  instruction, in_valid, flush, out_ready,
        output in_ready, out_valid, alu_op, rs_addr, rt_addr, rd_addr, imm,
               reg_read, reg_write, car_write, sel_imm, mem_read, mem_write,
               mem2reg, illegal, halt, halted, decode_count
    );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode stage with load-use interlock, sticky halt and flush.
module decode_stage #(
    parameter int unsigned NUM_REGS    = 12,
    parameter int unsigned INSTR_WIDTH = 9,
    parameter int unsigned REG_WIDTH   = 8,
    parameter int unsigned OP_WIDTH    = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    decode_if.slave  bus
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    typedef struct packed {
        logic [OP_WIDTH-1:0]  alu_op;
        logic [AW-1:0]        rs;
        logic [AW-1:0]        rt;
        logic [AW-1:0]        rd;
        logic [REG_WIDTH-1:0] imm;
        logic                 reg_read;
        logic                 reg_write;
        logic                 car_write;
        logic                 sel_imm;
        logic                 mem_read;
        logic                 mem_write;
        logic                 mem2reg;
        logic                 illegal;
        logic                 halt;
    } dec_t;

    dec_t                 dec;
    dec_t                 out_q;
    logic                 rs_used;
    logic                 rt_used;
    logic                 out_valid_q;
    logic                 halted_q;
    logic                 lw_pending;
    logic [AW-1:0]        lw_dest;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 hazard;
    logic                 in_ready;
    logic                 accept;
    logic                 lw_leave;

    logic [2:0] op;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] fc;

    assign op = bus.instruction[8:6];
    assign fa = bus.instruction[5:4];
    assign fb = bus.instruction[3:2];
    assign fc = bus.instruction[1:0];

    // Decode the incoming instruction and note which source registers it reads
    always_comb begin
        dec     = '0;
        rs_used = 1'b0;
        rt_used = 1'b0;
        case (op)
            3'b000: begin
                dec.rs        = AW'(fa) + AW'(4);
                dec.rt        = (fc == 2'b01) ? AW'(fb) + AW'(8) : AW'(fb);
                dec.rd        = AW'(11);
                dec.reg_read  = 1'b1;
                dec.reg_write = 1'b1;
                rs_used       = 1'b1;
                rt_used       = 1'b1;
                case (fc)
                    2'b00:   dec.alu_op = OP_WIDTH'(0);
                    2'b01:   dec.alu_op = OP_WIDTH'(1);
                    2'b10:   dec.alu_op = OP_WIDTH'(2);
                    default: dec.alu_op = OP_WIDTH'(5);
                endcase
            end
            3'b001: begin
                if (fc == 2'b00) begin
                    dec.alu_op    = OP_WIDTH'(6);
                    dec.rs        = AW'(fa) + AW'(4);
                    dec.rd        = AW'(fb);
                    dec.reg_read  = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.mem_read  = 1'b1;
                    dec.mem2reg   = 1'b1;
                    rs_used       = 1'b1;
                end else if (fc == 2'b01) begin
                    dec.alu_op    = OP_WIDTH'(6);
                    dec.rs        = AW'(fa) + AW'(4);
                    dec.rt        = AW'(fb);
                    dec.reg_read  = 1'b1;
                    dec.mem_write = 1'b1;
                    rs_used       = 1'b1;
                    rt_used       = 1'b1;
                end else begin
                    dec.illegal   = 1'b1;
                end
            end
            3'b010, 3'b100: begin
                dec.alu_op    = (op == 3'b010) ? OP_WIDTH'(4) : OP_WIDTH'(5);
                dec.rs        = AW'(fa) + AW'(4);
                dec.rt        = AW'(fb);
                dec.rd        = AW'(fc) + AW'(8);
                dec.reg_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.car_write = 1'b1;
                rs_used       = 1'b1;
                rt_used       = 1'b1;
            end
            3'b011: begin
                dec.alu_op    = OP_WIDTH'(4);
                dec.rs        = AW'(fb);
                dec.rd        = AW'(fa);
                dec.imm       = REG_WIDTH'(fc);
                dec.sel_imm   = 1'b1;
                dec.reg_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.car_write = 1'b1;
                rs_used       = 1'b1;
            end
            3'b101: begin
                dec.alu_op    = OP_WIDTH'(6);
                dec.rs        = AW'(bus.instruction[2:0]) + AW'(5);
                dec.rd        = AW'(bus.instruction[5:3]) + AW'(1);
                dec.reg_read  = 1'b1;
                dec.reg_write = 1'b1;
                rs_used       = 1'b1;
            end
            3'b110: begin
                dec.alu_op    = OP_WIDTH'(7);
                dec.rs        = AW'(fa) + AW'(4);
                dec.rt        = AW'(fb);
                dec.reg_read  = 1'b1;
                rs_used       = 1'b1;
                rt_used       = 1'b1;
            end
            default: begin
                if (fc == 2'b11) begin
                    dec.halt = 1'b1;
                end else begin
                    dec.alu_op    = OP_WIDTH'(8) + OP_WIDTH'(fc);
                    dec.rs        = AW'(fa) + AW'(4);
                    dec.rd        = AW'(fa) + AW'(4);
                    dec.rt        = AW'(fb);
                    dec.reg_read  = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.car_write = 1'b1;
                    rs_used       = 1'b1;
                    rt_used       = 1'b1;
                end
            end
        endcase
    end

    // Handshake: stall on a read of the register an LW just wrote, on halt or flush
    always_comb begin
        hazard   = lw_pending && ((rs_used && (dec.rs == lw_dest)) ||
                                  (rt_used && (dec.rt == lw_dest)));
        in_ready = !bus.flush && !halted_q && !hazard && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;
        lw_leave = out_valid_q && bus.out_ready && !bus.flush && out_q.mem_read;
    end

    // Output pipeline register, interlock tracking, halt latch and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            lw_pending  <= 1'b0;
            lw_dest     <= '0;
            count_q     <= '0;
        end else begin
            lw_pending <= lw_leave;
            if (lw_leave) begin
                lw_dest <= out_q.rd;
            end
            if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
                count_q     <= count_q + CNT_WIDTH'(1);
                if (dec.halt) begin
                    halted_q <= 1'b1;
                end
            end else if (bus.flush || bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.alu_op       = out_q.alu_op;
    assign bus.rs_addr      = out_q.rs;
    assign bus.rt_addr      = out_q.rt;
    assign bus.rd_addr      = out_q.rd;
    assign bus.imm          = out_q.imm;
    assign bus.reg_read     = out_q.reg_read;
    assign bus.reg_write    = out_q.reg_write;
    assign bus.car_write    = out_q.car_write;
    assign bus.sel_imm      = out_q.sel_imm;
    assign bus.mem_read     = out_q.mem_read;
    assign bus.mem_write    = out_q.mem_write;
    assign bus.mem2reg      = out_q.mem2reg;
    assign bus.illegal      = out_q.illegal;
    assign bus.halt         = out_q.halt;
    assign bus.halted       = halted_q;
    assign bus.decode_count = count_q;
endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a behavioural decode/handshake model.
module tb_decode_stage;
    localparam int unsigned NR = 12;
    localparam int unsigned IW = 9;
    localparam int unsigned RW = 8;
    localparam int unsigned OW = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] instr;
    logic          in_valid;
    logic          flush;
    logic          out_ready;

    decode_if #(.NUM_REGS(NR), .INSTR_WIDTH(IW), .REG_WIDTH(RW), .OP_WIDTH(OW), .CNT_WIDTH(CW)) bus ();
    decode_if #(.NUM_REGS(NR), .INSTR_WIDTH(IW), .REG_WIDTH(RW), .OP_WIDTH(OW), .CNT_WIDTH(4))  bus4 ();

    assign bus.instruction  = instr;
    assign bus.in_valid     = in_valid;
    assign bus.flush        = flush;
    assign bus.out_ready    = out_ready;
    assign bus4.instruction = instr;
    assign bus4.in_valid    = in_valid;
    assign bus4.flush       = flush;
    assign bus4.out_ready   = out_ready;

    decode_stage #(.NUM_REGS(NR), .INSTR_WIDTH(IW), .REG_WIDTH(RW), .OP_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    decode_stage #(.NUM_REGS(NR), .INSTR_WIDTH(IW), .REG_WIDTH(RW), .OP_WIDTH(OW), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );

    always #5 clk = ~clk;

    // flag order: reg_read reg_write car_write sel_imm mem_read mem_write mem2reg illegal halt
    typedef struct {
        int       alu, rs, rt, rd, imm;
        bit [8:0] fl;
        bit       rs_rd, rt_rd;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    bit   m_valid, m_halted, m_lw_pend;
    int   m_lw_dest, m_count;
    exp_t m_entry;
    bit   ir;
    int   saved;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input int x);
        exp_t e;
        int op, a, b, c;
        op = (x >> 6) & 7; a = (x >> 4) & 3; b = (x >> 2) & 3; c = x & 3;
        e = '{alu: 0, rs: 0, rt: 0, rd: 0, imm: 0, fl: 9'b0, rs_rd: 1'b0, rt_rd: 1'b0};
        case (op)
            0: begin
                e.alu = (c == 3) ? 5 : c;
                e.rs = a + 4; e.rt = (c == 1) ? b + 8 : b; e.rd = 11;
                e.fl = 9'b110000000; e.rs_rd = 1; e.rt_rd = 1;
            end
            1: begin
                if (c == 0) begin
                    e.alu = 6; e.rs = a + 4; e.rd = b; e.fl = 9'b110010100; e.rs_rd = 1;
                end else if (c == 1) begin
                    e.alu = 6; e.rs = a + 4; e.rt = b; e.fl = 9'b100001000; e.rs_rd = 1; e.rt_rd = 1;
                end else begin
                    e.fl = 9'b000000010;
                end
            end
            2, 4: begin
                e.alu = (op == 2) ? 4 : 5; e.rs = a + 4; e.rt = b; e.rd = c + 8;
                e.fl = 9'b111000000; e.rs_rd = 1; e.rt_rd = 1;
            end
            3: begin
                e.alu = 4; e.rs = b; e.rd = a; e.imm = c; e.fl = 9'b111100000; e.rs_rd = 1;
            end
            5: begin
                e.alu = 6; e.rs = (x & 7) + 5; e.rd = ((x >> 3) & 7) + 1; e.fl = 9'b110000000; e.rs_rd = 1;
            end
            6: begin
                e.alu = 7; e.rs = a + 4; e.rt = b; e.fl = 9'b100000000; e.rs_rd = 1; e.rt_rd = 1;
            end
            default: begin
                if (c == 3) begin
                    e.fl = 9'b000000001;
                end else begin
                    e.alu = 8 + c; e.rs = a + 4; e.rd = a + 4; e.rt = b;
                    e.fl = 9'b111000000; e.rs_rd = 1; e.rt_rd = 1;
                end
            end
        endcase
        return e;
    endfunction

    function automatic bit model_ready();
        exp_t d;
        bit   uses_dest;
        d = ref_decode(int'(instr));
        uses_dest = (d.rs_rd && d.rs == m_lw_dest) || (d.rt_rd && d.rt == m_lw_dest);
        return !flush && !m_halted && !(m_lw_pend && uses_dest) && (!m_valid || out_ready);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_halted = 0; m_lw_pend = 0; m_lw_dest = 0; m_count = 0;
    endtask

    // Advance the model across one rising edge given whether the stage accepted
    task automatic model_edge(input bit rdy);
        bit leave;
        leave     = m_valid && out_ready && !flush;
        m_lw_pend = leave && (m_entry.fl == 9'b110010100);
        if (m_lw_pend) m_lw_dest = m_entry.rd;
        if (in_valid && rdy) begin
            m_entry  = ref_decode(int'(instr));
            m_valid  = 1;
            m_count  = m_count + 1;
            if (m_entry.fl[0]) m_halted = 1;
        end else if (flush || out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        bit [8:0] dfl;
        dfl = {bus.reg_read, bus.reg_write, bus.car_write, bus.sel_imm, bus.mem_read,
               bus.mem_write, bus.mem2reg, bus.illegal, bus.halt};
        chk("out_valid", int'(bus.out_valid), int'(m_valid));
        chk("halted", int'(bus.halted), int'(m_halted));
        chk("decode_count", int'(bus.decode_count), m_count % 65536);
        chk("decode_count_w4", int'(bus4.decode_count), m_count % 16);
        if (m_valid) begin
            chk("alu_op", int'(bus.alu_op), m_entry.alu);
            chk("rs_addr", int'(bus.rs_addr), m_entry.rs);
            chk("rt_addr", int'(bus.rt_addr), m_entry.rt);
            chk("rd_addr", int'(bus.rd_addr), m_entry.rd);
            chk("imm", int'(bus.imm), m_entry.imm);
            chk("flags", int'(dfl), int'(m_entry.fl));
        end
    endtask

    // One cycle: drive inputs, check ready, clock, check registered outputs
    task automatic step(input logic [IW-1:0] i, input bit v, input bit f, input bit r);
        bit exp_ir;
        instr = i; in_valid = v; flush = f; out_ready = r;
        #1;
        exp_ir = model_ready();
        chk("in_ready", int'(bus.in_ready), int'(exp_ir));
        chk("in_ready_w4", int'(bus4.in_ready), int'(exp_ir));
        ir = bus.in_ready;
        @(posedge clk);
        model_edge(exp_ir);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [IW-1:0] ri;
        bit rv, rf, rr;
        rst_n = 0; instr = '0; in_valid = 0; flush = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_count", int'(bus.decode_count), 0);
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_alu_op", int'(bus.alu_op), 0);
        chk("rst_rd_addr", int'(bus.rd_addr), 0);
        rst_n = 1;

        // back-to-back ADD then ADDI
        step(9'h08B, 1, 0, 1);
        chk("add_alu", int'(bus.alu_op), 4);
        chk("add_rs", int'(bus.rs_addr), 4);
        chk("add_rt", int'(bus.rt_addr), 2);
        chk("add_rd", int'(bus.rd_addr), 11);
        chk("add_car", int'(bus.car_write), 1);
        step(9'h0DE, 1, 0, 1);
        chk("addi_rs", int'(bus.rs_addr), 3);
        chk("addi_rd", int'(bus.rd_addr), 1);
        chk("addi_imm", int'(bus.imm), 2);
        chk("addi_sel", int'(bus.sel_imm), 1);
        chk("addi_count", int'(bus.decode_count), 2);

        // backpressure on SW
        step(9'h065, 1, 0, 1);
        chk("sw_rs", int'(bus.rs_addr), 6);
        chk("sw_rt", int'(bus.rt_addr), 1);
        chk("sw_memw", int'(bus.mem_write), 1);
        for (int k = 0; k < 3; k++) begin
            step(9'h000, 1, 0, 0);
            chk("bp_in_ready", int'(ir), 0);
            chk("bp_rs_hold", int'(bus.rs_addr), 6);
        end
        step(9'h000, 1, 0, 1);
        chk("bp_release", int'(ir), 1);
        chk("bp_count", int'(bus.decode_count), 4);

        // load-use interlock
        step(9'h044, 1, 0, 1);
        chk("lw_rd", int'(bus.rd_addr), 1);
        chk("lw_memr", int'(bus.mem_read), 1);
        step(9'h000, 1, 0, 1);
        chk("lu_indep_ready", int'(ir), 1);
        step(9'h016, 1, 0, 1);
        chk("lu_stall", int'(ir), 0);
        step(9'h016, 1, 0, 1);
        chk("lu_accept", int'(ir), 1);
        chk("or_alu", int'(bus.alu_op), 2);

        // flush with an LW held, simultaneous out_ready
        step(9'h044, 1, 0, 1);
        step(9'h000, 1, 0, 0);
        saved = int'(bus.decode_count);
        step(9'h016, 1, 1, 1);
        chk("flush_ready", int'(ir), 0);
        chk("flush_valid", int'(bus.out_valid), 0);
        chk("flush_count", int'(bus.decode_count), saved);
        step(9'h016, 1, 0, 1);
        chk("flush_no_lw", int'(ir), 1);

        // illegal encoding
        step(9'h04A, 1, 0, 1);
        chk("ill_flag", int'(bus.illegal), 1);
        chk("ill_rr", int'(bus.reg_read), 0);

        // randomized traffic (HALT withheld)
        for (int n = 0; n < 3000; n++) begin
            ri = IW'($urandom_range(0, 511));
            if (ri[8:6] == 3'b111 && ri[1:0] == 2'b11) ri[1:0] = 2'b00;
            rv = ($urandom_range(0, 3) != 0);
            rf = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 9) < 7);
            step(ri, rv, rf, rr);
        end

        // HALT and its stickiness
        saved = int'(bus.decode_count);
        step(9'h1C3, 1, 0, 1);
        chk("halt_accept", int'(ir), 1);
        chk("halt_flag", int'(bus.halt), 1);
        chk("halted_set", int'(bus.halted), 1);
        step(9'h000, 1, 0, 0);
        chk("halted_ready", int'(ir), 0);
        step(9'h000, 1, 1, 1);
        chk("halted_after_flush", int'(bus.halted), 1);
        step(9'h000, 1, 0, 1);
        chk("halted_ready2", int'(ir), 0);
        chk("halted_count", int'(bus.decode_count), (saved + 1) % 65536);

        // asynchronous reset while halted
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("arst_halted", int'(bus.halted), 0);
        chk("arst_valid", int'(bus.out_valid), 0);
        chk("arst_count", int'(bus.decode_count), 0);
        chk("arst_count_w4", int'(bus4.decode_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        step(9'h08B, 1, 0, 1);
        chk("post_rst_accept", int'(ir), 1);
        chk("post_rst_count", int'(bus.decode_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
